// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared 7-segment glyph encodings and status codes used by the
//               scan driver and by game modes that build the seg_data bus.
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-low
    localparam seg_t GLYPH_0     = 7'h40;
    localparam seg_t GLYPH_1     = 7'h79;
    localparam seg_t GLYPH_2     = 7'h24;
    localparam seg_t GLYPH_3     = 7'h30;
    localparam seg_t GLYPH_4     = 7'h19;
    localparam seg_t GLYPH_5     = 7'h12;
    localparam seg_t GLYPH_6     = 7'h02;
    localparam seg_t GLYPH_7     = 7'h78;
    localparam seg_t GLYPH_8     = 7'h00;
    localparam seg_t GLYPH_9     = 7'h10;
    localparam seg_t GLYPH_B_LC  = 7'h03;
    localparam seg_t GLYPH_S     = 7'h12;
    localparam seg_t GLYPH_L     = 7'h47;
    localparam seg_t GLYPH_D_LC  = 7'h21;
    localparam seg_t GLYPH_E     = 7'h06;
    localparam seg_t GLYPH_BLANK = 7'h7F;

    localparam seg_t        SEG_BLANK = 7'h7F;
    localparam logic [3:0]  AN_OFF    = 4'hF;

    // Status glyph codes placed on the seg_data nibble bus
    localparam logic [3:0] CODE_b     = 4'hA;
    localparam logic [3:0] CODE_S     = 4'hB;
    localparam logic [3:0] CODE_L     = 4'hC;
    localparam logic [3:0] CODE_d     = 4'hD;
    localparam logic [3:0] CODE_E     = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

endpackage
`default_nettype wire

// File: rtl/seg7_glyph_rom.sv
`default_nettype none
// ============================================================================
// Module      : seg7_glyph_rom
// Description : Combinational 4-bit code to active-low 7-segment pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_glyph_rom
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'h0:       o_seg = GLYPH_0;
            4'h1:       o_seg = GLYPH_1;
            4'h2:       o_seg = GLYPH_2;
            4'h3:       o_seg = GLYPH_3;
            4'h4:       o_seg = GLYPH_4;
            4'h5:       o_seg = GLYPH_5;
            4'h6:       o_seg = GLYPH_6;
            4'h7:       o_seg = GLYPH_7;
            4'h8:       o_seg = GLYPH_8;
            4'h9:       o_seg = GLYPH_9;
            CODE_b:     o_seg = GLYPH_B_LC;
            CODE_S:     o_seg = GLYPH_S;
            CODE_L:     o_seg = GLYPH_L;
            CODE_d:     o_seg = GLYPH_D_LC;
            CODE_E:     o_seg = GLYPH_E;
            CODE_BLANK: o_seg = GLYPH_BLANK;
            default:    o_seg = SEG_BLANK;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Latches the 16-bit nibble bus once per frame and scans it onto
//               a 4-digit common-anode display with blanking and PWM dimming.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100_000,
    parameter int BLANK_CYC   = 1_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] seg_data,
    input  logic [3:0]  dp_mask,
    input  logic [2:0]  brightness,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W     = $clog2(REFRESH_DIV);
    localparam int SLICE_LEN = REFRESH_DIV / 8;
    localparam int SLICE_W   = $clog2(SLICE_LEN);

    localparam logic [CNT_W-1:0]   c_div_last   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   c_blank_cyc  = CNT_W'(BLANK_CYC);
    localparam logic [SLICE_W-1:0] c_slice_last = SLICE_W'(SLICE_LEN - 1);

    logic [CNT_W-1:0]   r_div_cnt;
    logic [SLICE_W-1:0] r_slice_cnt;
    logic [2:0]         r_slice_idx;
    logic [1:0]         r_digit_idx;
    logic [15:0]        r_shadow;
    logic [3:0]         r_dp_shadow;
    logic [2:0]         r_bright_shadow;

    logic               w_div_wrap;
    logic               w_slice_wrap;
    logic               w_frame_latch;
    logic               w_active;
    logic [3:0]         w_nibble;
    logic [6:0]         w_glyph;

    assign w_div_wrap    = (r_div_cnt == c_div_last);
    assign w_slice_wrap  = (r_slice_cnt == c_slice_last);
    assign w_frame_latch = w_div_wrap && (r_digit_idx == 2'd3);

    // Slice index tracks div_cnt / SLICE_LEN without a divider
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div_cnt   <= '0;
            r_slice_cnt <= '0;
            r_slice_idx <= 3'd0;
            r_digit_idx <= 2'd0;
        end else begin
            if (w_div_wrap) begin
                r_div_cnt   <= '0;
                r_slice_cnt <= '0;
                r_slice_idx <= 3'd0;
                r_digit_idx <= r_digit_idx + 2'd1;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
                if (w_slice_wrap) begin
                    r_slice_cnt <= '0;
                    r_slice_idx <= r_slice_idx + 3'd1;
                end else begin
                    r_slice_cnt <= r_slice_cnt + 1'b1;
                end
            end
        end
    end

    // Frame-coherent copies of the inputs so a frame never tears
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow        <= 16'hFFFF;
            r_dp_shadow     <= 4'h0;
            r_bright_shadow <= 3'd7;
        end else if (w_frame_latch) begin
            r_shadow        <= seg_data;
            r_dp_shadow     <= dp_mask;
            r_bright_shadow <= brightness;
        end
    end

    always_comb begin
        w_nibble = r_shadow[3:0];
        case (r_digit_idx)
            2'd0: w_nibble = r_shadow[3:0];
            2'd1: w_nibble = r_shadow[7:4];
            2'd2: w_nibble = r_shadow[11:8];
            2'd3: w_nibble = r_shadow[15:12];
            default: w_nibble = r_shadow[3:0];
        endcase
    end

    seg7_glyph_rom u_glyph_rom (
        .i_code (w_nibble),
        .o_seg  (w_glyph)
    );

    assign w_active = enable
                   && (r_div_cnt >= c_blank_cyc)
                   && (r_slice_idx <= r_bright_shadow);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_frame_latch;
            if (w_active) begin
                an  <= ~(4'b0001 << r_digit_idx);
                seg <= w_glyph;
                dp  <= ~r_dp_shadow[r_digit_idx];
            end else begin
                an  <= AN_OFF;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Directed self-checking bench for seg7_scan_driver with a
//               16-cycle slot (REFRESH_DIV=16, BLANK_CYC=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [15:0] seg_data;
    logic [3:0]  dp_mask;
    logic [2:0]  brightness;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int now   = 0;
    int lit;
    int pulses;

    logic [3:0] exp_an [4];
    logic [6:0] exp_f1 [4];
    logic [6:0] exp_f2 [4];

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .REFRESH_DIV (16),
        .BLANK_CYC   (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .seg_data    (seg_data),
        .dp_mask     (dp_mask),
        .brightness  (brightness),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h cycle=%0d", tag, obs, exp, now);
        end
    endtask

    // Cycle c = c-th negedge after the last reset edge
    task automatic goto(input int c);
        while (now < c) begin
            @(negedge clk);
            now++;
        end
    endtask

    initial begin
        exp_an = '{4'hE, 4'hD, 4'hB, 4'h7};
        exp_f1 = '{7'h19, 7'h30, 7'h24, 7'h79};
        exp_f2 = '{7'h21, 7'h40, 7'h40, 7'h10};

        reset_n    = 1'b0;
        enable     = 1'b1;
        seg_data   = 16'h1234;
        dp_mask    = 4'h0;
        brightness = 3'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        now = 0;
        chk("rst_an", {12'h0, an}, 16'hF);
        chk("rst_seg", {9'h0, seg}, 16'h7F);
        chk("rst_dp", {15'h0, dp}, 16'h1);
        chk("rst_fs", {15'h0, frame_start}, 16'h0);
        reset_n = 1'b1;

        // Before the first latch the shadow is blank but anodes still scan
        pulses = 0;
        for (int c = 1; c <= 63; c++) begin
            goto(c);
            if (c == 2) begin
                chk("prelatch_an", {12'h0, an}, 16'hE);
                chk("prelatch_seg", {9'h0, seg}, 16'h7F);
            end
            if (frame_start) pulses++;
        end
        chk("no_early_fs", 16'(pulses), 16'd0);
        goto(64);
        chk("first_fs", {15'h0, frame_start}, 16'h1);
        goto(65);
        chk("fs_one_cycle", {15'h0, frame_start}, 16'h0);

        // Frame 1: 1234; change input mid-frame during digit 1
        for (int d = 0; d < 4; d++) begin
            goto(65 + 16 * d);
            chk("f1_blank_an", {12'h0, an}, 16'hF);
            goto(66 + 16 * d);
            chk("f1_an_first", {12'h0, an}, {12'h0, exp_an[d]});
            chk("f1_seg_first", {9'h0, seg}, {9'h0, exp_f1[d]});
            if (d == 1) begin
                goto(69 + 16 * d);
                seg_data = 16'h900D;
            end
            goto(80 + 16 * d);
            chk("f1_an_last", {12'h0, an}, {12'h0, exp_an[d]});
            chk("f1_seg_last", {9'h0, seg}, {9'h0, exp_f1[d]});
        end
        goto(128);
        chk("f1_fs", {15'h0, frame_start}, 16'h1);
        brightness = 3'd0;

        // Frame 2: 900D
        for (int d = 0; d < 4; d++) begin
            goto(130 + 16 * d);
            chk("f2_an", {12'h0, an}, {12'h0, exp_an[d]});
            chk("f2_seg", {9'h0, seg}, {9'h0, exp_f2[d]});
            chk("f2_dp", {15'h0, dp}, 16'h1);
            goto(144 + 16 * d);
            chk("f2_seg_last", {9'h0, seg}, {9'h0, exp_f2[d]});
        end

        // Frame 3: brightness 0 -> one lit cycle per slot
        lit = 0;
        for (int c = 193; c <= 256; c++) begin
            goto(c);
            if (c == 193) brightness = 3'd3;
            if (c == 194) begin
                chk("b0_lit_an", {12'h0, an}, 16'hE);
                chk("b0_lit_seg", {9'h0, seg}, 16'h21);
            end
            if (c == 195) chk("b0_off_an", {12'h0, an}, 16'hF);
            if (an != 4'hF) lit++;
        end
        chk("b0_lit_count", 16'(lit), 16'd4);

        // Frame 4: brightness 3 -> seven lit cycles per slot
        lit = 0;
        for (int c = 257; c <= 320; c++) begin
            goto(c);
            if (c == 257) begin
                brightness = 3'd7;
                dp_mask    = 4'b0100;
                seg_data   = 16'hFFFF;
            end
            if (c == 264) chk("b3_last_lit", {12'h0, an}, 16'hE);
            if (c == 265) chk("b3_first_off", {12'h0, an}, 16'hF);
            if (an != 4'hF) lit++;
        end
        chk("b3_lit_count", 16'(lit), 16'd28);

        // Frame 5: blank glyphs, decimal point on digit 2 only
        goto(322);
        chk("dp_d0_an", {12'h0, an}, 16'hE);
        chk("dp_d0", {15'h0, dp}, 16'h1);
        goto(354);
        chk("dp_d2_an", {12'h0, an}, 16'hB);
        chk("dp_d2_seg", {9'h0, seg}, 16'h7F);
        chk("dp_d2", {15'h0, dp}, 16'h0);
        goto(368);
        chk("dp_d2_last", {15'h0, dp}, 16'h0);
        goto(370);
        chk("dp_d3", {15'h0, dp}, 16'h1);

        goto(380);
        chk("pre_dis_an", {12'h0, an}, 16'h7);
        enable = 1'b0;
        goto(381);
        chk("dis_an", {12'h0, an}, 16'hF);
        pulses = 0;
        lit    = 0;
        for (int c = 381; c <= 460; c++) begin
            goto(c);
            if (c == 448) chk("dis_fs_448", {15'h0, frame_start}, 16'h1);
            if (frame_start) pulses++;
            if (an != 4'hF) lit++;
        end
        chk("dis_fs_count", 16'(pulses), 16'd2);
        chk("dis_dark", 16'(lit), 16'd0);
        enable   = 1'b1;
        seg_data = 16'h1234;

        // Frame 8 shows 1234; reset during digit 2
        goto(548);
        chk("pre_rst_an", {12'h0, an}, 16'hB);
        chk("pre_rst_seg", {9'h0, seg}, 16'h24);
        reset_n = 1'b0;
        goto(549);
        chk("mid_rst_an", {12'h0, an}, 16'hF);
        chk("mid_rst_seg", {9'h0, seg}, 16'h7F);
        chk("mid_rst_fs", {15'h0, frame_start}, 16'h0);
        reset_n = 1'b1;
        goto(550);
        chk("post_rst_blank", {12'h0, an}, 16'hF);
        goto(551);
        chk("post_rst_an", {12'h0, an}, 16'hE);
        chk("post_rst_seg", {9'h0, seg}, 16'h7F);
        chk("post_rst_dp", {15'h0, dp}, 16'h1);
        goto(612);
        chk("post_rst_d3_an", {12'h0, an}, 16'h7);
        chk("post_rst_d3_seg", {9'h0, seg}, 16'h7F);
        chk("post_rst_nofs", {15'h0, frame_start}, 16'h0);
        goto(613);
        chk("post_rst_fs", {15'h0, frame_start}, 16'h1);
        goto(615);
        chk("relatch_an", {12'h0, an}, 16'hE);
        chk("relatch_seg", {9'h0, seg}, 16'h19);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
